// File: rtl/instr_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : instr_sequencer_pkg
// Brief    : Shared opcode constants, instruction field layout and sequencer
//            state encoding for the 8-bit CPU fetch/execute controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_sequencer_pkg;

  // Control-flow opcodes handled by the sequencer itself
  localparam logic [7:0] OP_JMP = 8'h10;
  localparam logic [7:0] OP_HLT = 8'h1F;

  // Instruction word layout: opcode [23:16], arg_a [15:8], arg_b [7:0]
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] arg_a;
    logic [7:0] arg_b;
  } instr_t;

  // Sequencer state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_pc_unit.sv
//------------------------------------------------------------------------------
// Module   : pc_unit
// Brief    : Program counter register with load / increment / hold select.
//            Load has priority over increment; increment wraps modulo 2^ADDR_W.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // PC register: load target, step by one, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// Module   : instr_sequencer
// Brief    : Fetch/execute controller. Drives the synchronous instruction ROM,
//            latches the instruction register, strobes exec_valid once per
//            instruction and handles JMP / HLT. Three cycles per instruction.
//            Optional feature macro: SEQ_SINGLE_STEP_EN (adds the step port,
//            one-instruction execution out of HALT).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt_req,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [23:0]       ir,
  output logic              exec_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  seq_state_t state;
  seq_state_t state_nxt;
  instr_t     ir_q;
  logic       pc_inc;
  logic       pc_load;
  logic       step_hold;

  assign ir       = ir_q;
  assign rom_addr = pc;

`ifdef SEQ_SINGLE_STEP_EN
  // Remembers that the instruction in flight was launched by a step pulse
  logic step_hold_nxt;

  // Step-mode flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_hold <= 1'b0;
    end else begin
      step_hold <= step_hold_nxt;
    end
  end
`else
  assign step_hold = 1'b0;
`endif

  // State register and instruction register (loaded while the ROM word is valid)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT) begin
        ir_q <= instr_t'(rom_data);
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt  = state;
    rom_rd_en  = 1'b0;
    exec_valid = 1'b0;
    halted     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_hold_nxt = step_hold;
`endif
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        rom_rd_en = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        exec_valid = 1'b1;
        if (ir_q.opcode == OP_JMP) begin
          pc_load = 1'b1;
        end else if (ir_q.opcode != OP_HLT) begin
          pc_inc = 1'b1;
        end
        // halt_req beats run here; a stepped instruction always returns to HALT
        if (ir_q.opcode == OP_HLT || halt_req || step_hold) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_FETCH;
        end
`ifdef SEQ_SINGLE_STEP_EN
        step_hold_nxt = 1'b0;
`endif
      end
      ST_HALT: begin
        halted = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        if (step) begin
          state_nxt     = ST_FETCH;
          step_hold_nxt = 1'b1;
        end else if (run) begin
          state_nxt = ST_FETCH;
        end
`else
        if (run) state_nxt = ST_FETCH;
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (ADDR_W'(ir_q.arg_a)),
    .pc       (pc)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_sequencer
// Brief    : Directed self-checking bench for instr_sequencer with a ROM model
//            and a tiny GPR decoder model. Single-step scenario is built only
//            when SEQ_SINGLE_STEP_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_sequencer;

  localparam logic [7:0] T_NOP = 8'h00;
  localparam logic [7:0] T_LDR = 8'h01;  // r[a] <= b
  localparam logic [7:0] T_INC = 8'h02;  // r[a] <= r[a] + 1
  localparam logic [7:0] T_ADD = 8'h03;  // r[a] <= r[a] + r[b]
  localparam logic [7:0] T_JMP = 8'h10;
  localparam logic [7:0] T_HLT = 8'h1F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        halt_req;
  logic        step;
  logic        rom_rd_en;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic [23:0] ir;
  logic        exec_valid;
  logic [7:0]  pc;
  logic        halted;

  logic [23:0] rom [0:255];
  logic [7:0]  gpr [0:3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_sequencer #(
    .ADDR_W   (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .halt_req   (halt_req),
`ifdef SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .rom_rd_en  (rom_rd_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ir         (ir),
    .exec_valid (exec_valid),
    .pc         (pc),
    .halted     (halted)
  );

  // Synchronous ROM: word valid the cycle after the read strobe
  always @(posedge clk) begin
    if (rom_rd_en) rom_data <= rom[rom_addr];
  end

  // GPR model: commits mid-cycle while exec_valid is high
  always @(negedge clk) begin
    if (exec_valid) begin
      case (ir[23:16])
        T_LDR: gpr[ir[9:8]] <= ir[7:0];
        T_INC: gpr[ir[9:8]] <= gpr[ir[9:8]] + 8'd1;
        T_ADD: gpr[ir[9:8]] <= gpr[ir[9:8]] + gpr[ir[1:0]];
        default: ;
      endcase
    end
  end

  function automatic logic [23:0] ins(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    return {op, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(T_NOP, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    run      = 1'b0;
    halt_req = 1'b0;
    step     = 1'b0;
    for (int i = 0; i < 4; i++) gpr[i] = 8'h00;
    clear_rom();
    #1;
    rst_n = 1'b0;
    tick();

    // Reset state
    check("rst_pc", pc, 8'h00);
    check("rst_ir", ir, 24'h0);
    check("rst_exec_valid", exec_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_rom_rd_en", rom_rd_en, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_fetch", rom_rd_en, 1'b0);

    // Basic fetch and increment
    rom[0] = ins(T_LDR, 8'h01, 8'h05);
    rom[1] = ins(T_INC, 8'h01, 8'h00);
    rom[2] = ins(T_HLT, 8'h00, 8'h00);
    pulse_run();
    check("basic_fetch_en", rom_rd_en, 1'b1);
    check("basic_fetch_addr", rom_addr, 8'h00);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      check($sformatf("basic_ev_c%0d", cyc), exec_valid, (cyc % 3 == 0) ? 1'b1 : 1'b0);
      tick();
    end
    check("basic_halted", halted, 1'b1);
    check("basic_pc", pc, 8'h02);
    check("basic_r1", gpr[1], 8'h06);
    check("basic_halt_no_read", rom_rd_en, 1'b0);

    // Jump
    do_reset();
    clear_rom();
    rom[0]    = ins(T_JMP, 8'h20, 8'h00);
    rom[8'h20] = ins(T_HLT, 8'h00, 8'h00);
    pulse_run();
    check("jmp_fetch0", rom_addr, 8'h00);
    tick();
    tick();
    check("jmp_exec", exec_valid, 1'b1);
    tick();
    check("jmp_fetch_en", rom_rd_en, 1'b1);
    check("jmp_fetch_addr", rom_addr, 8'h20);
    tick();
    tick();
    tick();
    check("jmp_pc", pc, 8'h20);
    check("jmp_halted", halted, 1'b1);

    // Halt request during WAIT of the instruction at pc=4
    do_reset();
    clear_rom();
    pulse_run();
    for (int i = 0; i < 13; i++) tick();
    check("hreq_wait_pc", pc, 8'h04);
    halt_req = 1'b1;
    tick();
    check("hreq_exec_valid", exec_valid, 1'b1);
    tick();
    check("hreq_halted", halted, 1'b1);
    check("hreq_pc", pc, 8'h05);
    // run wins over halt_req in HALT; halt_req then wins again in EXEC
    run = 1'b1;
    tick();
    run = 1'b0;
    check("resume_fetch_en", rom_rd_en, 1'b1);
    check("resume_fetch_addr", rom_addr, 8'h05);
    tick();
    tick();
    check("resume_exec", exec_valid, 1'b1);
    tick();
    halt_req = 1'b0;
    check("rehalt_halted", halted, 1'b1);
    check("rehalt_pc", pc, 8'h06);

    // PC wrap
    do_reset();
    clear_rom();
    rom[0] = ins(T_JMP, 8'hFF, 8'h00);
    pulse_run();
    for (int i = 0; i < 3; i++) tick();
    check("wrap_fetch_ff", rom_addr, 8'hFF);
    for (int i = 0; i < 3; i++) tick();
    check("wrap_fetch_en", rom_rd_en, 1'b1);
    check("wrap_fetch_00", rom_addr, 8'h00);

    // Reset during EXEC of ADD r0,r1
    do_reset();
    clear_rom();
    rom[0] = ins(T_LDR, 8'h00, 8'h11);
    rom[1] = ins(T_LDR, 8'h01, 8'h22);
    rom[2] = ins(T_ADD, 8'h00, 8'h01);
    pulse_run();
    for (int i = 0; i < 8; i++) tick();
    check("abort_in_exec", exec_valid, 1'b1);
    check("abort_ir_add", ir[23:16], T_ADD);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_exec_valid", exec_valid, 1'b0);
    check("abort_halted", halted, 1'b0);
    check("abort_pc", pc, 8'h00);
    tick();
    check("abort_r0", gpr[0], 8'h11);
    rst_n = 1'b1;
    tick();
    tick();
    check("abort_idle", rom_rd_en, 1'b0);

`ifdef SEQ_SINGLE_STEP_EN
    // Single step from HALT at pc=3
    do_reset();
    clear_rom();
    pulse_run();
    for (int i = 0; i < 7; i++) tick();
    halt_req = 1'b1;
    tick();
    tick();
    halt_req = 1'b0;
    check("step_pre_halted", halted, 1'b1);
    check("step_pre_pc", pc, 8'h03);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_fetch_addr", rom_addr, 8'h03);
    check("step_fetch_en", rom_rd_en, 1'b1);
    tick();
    tick();
    check("step_exec", exec_valid, 1'b1);
    tick();
    check("step_halted", halted, 1'b1);
    check("step_pc", pc, 8'h04);
    tick();
    tick();
    check("step_no_fetch", rom_rd_en, 1'b0);
    check("step_still_pc", pc, 8'h04);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
